// File: rtl/jump_buzzer_pkg.sv
// rtl/jump_buzzer_pkg.sv - note frequencies, tone counter width and half-period helper
// Shared by jump_buzzer (chime gated by JUMP_BUZZER_CHIME_EN) and jump_buzzer_tone.
package jump_buzzer_pkg;

  localparam int TONE_W = 20;
  localparam logic [TONE_W-1:0] TONE_ONE = TONE_W'(1);

  localparam int NOTE_C4 = 262;
  localparam int NOTE_D4 = 294;
  localparam int NOTE_E4 = 330;
  localparam int NOTE_F4 = 349;
  localparam int NOTE_G4 = 392;
  localparam int NOTE_A4 = 440;
  localparam int NOTE_B4 = 494;
  localparam int NOTE_C5 = 523;

  typedef enum logic [3:0] {
    IDX_SILENT = 4'd0,
    IDX_C4     = 4'd1,
    IDX_D4     = 4'd2,
    IDX_E4     = 4'd3,
    IDX_F4     = 4'd4,
    IDX_G4     = 4'd5,
    IDX_A4     = 4'd6,
    IDX_B4     = 4'd7,
    IDX_CHIME  = 4'd8
  } note_idx_t;

  function automatic logic [TONE_W-1:0] hp_count(input int clk_hz, input int f);
    int hp;
    hp = clk_hz / (2 * f);
    return hp[TONE_W-1:0];
  endfunction

endpackage

// File: rtl/jump_buzzer_tone.sv
// rtl/jump_buzzer_tone.sv - 50% duty square wave from a half-period count
// Disabled holds the wave low; restart clears the count but keeps the wave level.
module jump_buzzer_tone
  import jump_buzzer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TONE_W-1:0] half_period,
  input  logic              enable,
  input  logic              restart,
  output logic              wave
);

  logic [TONE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt == half_period - TONE_ONE) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + TONE_ONE;
    end
  end

endmodule

// File: rtl/jump_buzzer.sv
// rtl/jump_buzzer.sv - piezo driver: charge-level pitch plus landing chime
// Landing chime only exists when JUMP_BUZZER_CHIME_EN is defined.
module jump_buzzer
  import jump_buzzer_pkg::*;
#(
  parameter int CLK_HZ  = 25_175_000,
  parameter int DONE_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] music_scale,
  input  logic       i_load_done,
  output logic       beep
);

  localparam logic [TONE_W-1:0] HP_C4 = hp_count(CLK_HZ, NOTE_C4);
  localparam logic [TONE_W-1:0] HP_D4 = hp_count(CLK_HZ, NOTE_D4);
  localparam logic [TONE_W-1:0] HP_E4 = hp_count(CLK_HZ, NOTE_E4);
  localparam logic [TONE_W-1:0] HP_F4 = hp_count(CLK_HZ, NOTE_F4);
  localparam logic [TONE_W-1:0] HP_G4 = hp_count(CLK_HZ, NOTE_G4);
  localparam logic [TONE_W-1:0] HP_A4 = hp_count(CLK_HZ, NOTE_A4);
  localparam logic [TONE_W-1:0] HP_B4 = hp_count(CLK_HZ, NOTE_B4);
  localparam logic [TONE_W-1:0] HP_C5 = hp_count(CLK_HZ, NOTE_C5);

  note_idx_t         scale_idx;
  note_idx_t         active_idx;
  note_idx_t         prev_idx;
  logic [TONE_W-1:0] half_period;
  logic              chime_on;

`ifdef JUMP_BUZZER_CHIME_EN
  localparam int CHIME_TICKS = CLK_HZ / 1000 * DONE_MS;
  localparam int CHIME_W     = $clog2(CHIME_TICKS + 1);

  logic [CHIME_W-1:0] chime_timer;
  logic               done_q;

  // A fresh rising edge always reloads, so a second landing restarts the chime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chime_timer <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= i_load_done;
      if (i_load_done && !done_q) begin
        chime_timer <= CHIME_W'(CHIME_TICKS);
      end else if (chime_timer != '0) begin
        chime_timer <= chime_timer - CHIME_W'(1);
      end
    end
  end

  assign chime_on = (chime_timer != '0);
`else
  logic unused_load_done;
  assign unused_load_done = i_load_done;
  assign chime_on         = 1'b0;
`endif

  always_comb begin
    if (music_scale > 4'd7) begin
      scale_idx = IDX_B4;
    end else begin
      scale_idx = note_idx_t'(music_scale);
    end
    active_idx = chime_on ? IDX_CHIME : scale_idx;
  end

  always_comb begin
    case (active_idx)
      IDX_C4:    half_period = HP_C4;
      IDX_D4:    half_period = HP_D4;
      IDX_E4:    half_period = HP_E4;
      IDX_F4:    half_period = HP_F4;
      IDX_G4:    half_period = HP_G4;
      IDX_A4:    half_period = HP_A4;
      IDX_B4:    half_period = HP_B4;
      IDX_CHIME: half_period = HP_C5;
      default:   half_period = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_idx <= IDX_SILENT;
    end else begin
      prev_idx <= active_idx;
    end
  end

  jump_buzzer_tone u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .half_period (half_period),
    .enable      (active_idx != IDX_SILENT),
    .restart     (active_idx != prev_idx),
    .wave        (beep)
  );

endmodule

// File: tb/tb_jump_buzzer.sv
// tb/tb_jump_buzzer.sv - scoreboard bench for jump_buzzer against an edge-timing model
// Honours JUMP_BUZZER_CHIME_EN the same way the design does.
module tb_jump_buzzer;

`ifdef JUMP_BUZZER_CHIME_EN
  localparam bit CHIME_EN = 1'b1;
`else
  localparam bit CHIME_EN = 1'b0;
`endif
  localparam int CLK_HZ  = 1_000_000;
  localparam int CHIME_N = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] music_scale;
  logic       i_load_done;
  logic       beep;

  typedef struct {
    int t;
    bit v;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  logic mon_last = 1'b0;

  // Reference model state: current note stretch and chime window end.
  int m_note;
  int m_start;
  bit m_v0;
  bit m_exp;
  int chime_end;
  bit m_prev_done;

  jump_buzzer #(.CLK_HZ(CLK_HZ), .DONE_MS(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .music_scale (music_scale),
    .i_load_done (i_load_done),
    .beep        (beep)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hp_of(input int a);
    int f;
    case (a)
      1: f = 262;
      2: f = 294;
      3: f = 330;
      4: f = 349;
      5: f = 392;
      6: f = 440;
      7: f = 494;
      default: f = 523;
    endcase
    return CLK_HZ / (2 * f);
  endfunction

  task automatic model_reset();
    m_note      = 0;
    m_start     = 0;
    m_v0        = 1'b0;
    m_exp       = 1'b0;
    chime_end   = -1;
    m_prev_done = 1'b0;
  endtask

  // Expected beep after edge t: stretch level flips every HP edges from the stretch start.
  task automatic model_step(input int t, input int s, input bit d);
    int a;
    bit e;
    if (CHIME_EN && t <= chime_end) a = 8;
    else if (s == 0)                a = 0;
    else if (s > 7)                 a = 7;
    else                            a = s;
    if (CHIME_EN && d && !m_prev_done) chime_end = t + CHIME_N;
    m_prev_done = d;
    if (a != m_note) begin
      m_note  = a;
      m_start = t;
      m_v0    = m_exp;
    end
    if (a == 0) e = 1'b0;
    else        e = m_v0 ^ ((((t - m_start) / hp_of(a)) % 2) == 1);
    if (e != m_exp) exp_q.push_back('{t, e});
    m_exp = e;
  endtask

  task automatic run(input int s, input bit d, input int n);
    for (int i = 0; i < n; i++) begin
      music_scale = 4'(s);
      i_load_done = d;
      model_step(cyc + 1, s, d);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_low(input string name);
    total++;
    if (beep !== 1'b0) begin
      bad++;
      $display("FAIL %s: beep=%b required 0 at cyc=%0d", name, beep, cyc);
    end
  endtask

  task automatic pulse_reset();
    if (m_exp) exp_q.push_back('{cyc, 1'b0});
    i_load_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check_low("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (beep !== mon_last) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_edge: cyc=%0d beep=%b required no change", cyc, beep);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.t != cyc || beep !== mon_ev.v) begin
          bad++;
          $display("FAIL edge: cyc=%0d beep=%b required cyc=%0d beep=%b",
                   cyc, beep, mon_ev.t, mon_ev.v);
        end
      end
      mon_last = beep;
    end
    while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
      mon_ev = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_edge: cyc=%0d beep=%b required beep=%b at cyc=%0d",
               cyc, beep, mon_ev.v, mon_ev.t);
    end
  end

  initial begin
    model_reset();
    rst_n       = 1'b1;
    music_scale = 4'd0;
    i_load_done = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_low("reset_state");
    rst_n = 1'b1;

    run(0, 1'b0, 10000);
    check_low("silent_after_reset");

    run(6, 1'b0, 6000);
    run(12, 1'b0, 3000);
    run(7, 1'b0, 1500);
    run(1, 1'b0, 4000);

    run(3, 1'b0, 2000);
    run(3, 1'b1, 3000);
    run(3, 1'b0, 500);
    run(3, 1'b1, 500);
    run(3, 1'b0, 1);
    run(3, 1'b1, 2000);
    run(3, 1'b0, 200);
    run(3, 1'b1, 300);
    pulse_reset();
    run(3, 1'b0, 3000);

    repeat (12) begin
      run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          int'($urandom_range(200, 2500)));
    end
    run(0, 1'b0, 50);
    check_low("silent_at_end");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_edges: left=%0d required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
